// File: rtl/connect_four_engine.sv
// rtl/connect_four_engine.sv - Connect Four game-state engine: buttons, cursor, drop and win/draw check
// Ports: clk, rst (async, active-high); move_right/move_left/drop_piece are raw buttons;
//        row_read/col_read select the cell driven on data_out (00 empty, 01 P1, 10 P2);
//        current_col, current_player, game_over, winner and busy report game state.
module connect_four_engine #(
    parameter int WIN_LEN     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_right,
    input  logic       move_left,
    input  logic       drop_piece,
    input  logic [2:0] row_read,
    input  logic [2:0] col_read,
    output logic [1:0] data_out,
    output logic [2:0] current_col,
    output logic [1:0] current_player,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SCAN, PLACE, CHK_POS, CHK_NEG, NEXT_DIR, RESOLVE, CLEAR} state_t;
    localparam logic [3:0] WIN = 4'(WIN_LEN);

    state_t state, next_state;

    logic [1:0] board [8][8];
    logic [SYNC_STAGES-1:0] sync_r, sync_l, sync_d, warm;
    logic prev_r, prev_l, prev_d, arm_r, arm_l, arm_d;
    logic lvl_r, lvl_l, lvl_d, ev_r, ev_l, ev_d;

    logic [2:0] scan_row, pl_row, pl_col;
    logic [6:0] move_cnt;
    logic [1:0] dir_idx;
    logic [3:0] run_cnt;
    logic signed [3:0] probe_r, probe_c, dr, dc, nr, nc;
    logic in_bounds, take_step, stop_dir, scan_empty, win;

    assign lvl_r = sync_r[SYNC_STAGES-1];
    assign lvl_l = sync_l[SYNC_STAGES-1];
    assign lvl_d = sync_d[SYNC_STAGES-1];
    // An edge only counts once the button has been seen released after reset,
    // so a button held through reset never produces an event.
    assign ev_r = lvl_r & ~prev_r & arm_r;
    assign ev_l = lvl_l & ~prev_l & arm_l;
    assign ev_d = lvl_d & ~prev_d & arm_d;

    assign data_out = board[row_read][col_read];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0; sync_l <= '0; sync_d <= '0; warm <= '0;
            prev_r <= 1'b0; prev_l <= 1'b0; prev_d <= 1'b0;
            arm_r  <= 1'b0; arm_l  <= 1'b0; arm_d  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], move_right};
            sync_l <= {sync_l[SYNC_STAGES-2:0], move_left};
            sync_d <= {sync_d[SYNC_STAGES-2:0], drop_piece};
            // warm marks when the synchroniser outputs reflect real samples
            warm   <= {warm[SYNC_STAGES-2:0], 1'b1};
            prev_r <= lvl_r; prev_l <= lvl_l; prev_d <= lvl_d;
            arm_r  <= arm_r | (warm[SYNC_STAGES-1] & ~lvl_r);
            arm_l  <= arm_l | (warm[SYNC_STAGES-1] & ~lvl_l);
            arm_d  <= arm_d | (warm[SYNC_STAGES-1] & ~lvl_d);
        end
    end

    always_comb begin
        dr = 4'sd1;
        dc = 4'sd0;
        case (dir_idx)
            2'd0: begin dr = 4'sd0; dc = 4'sd1;  end
            2'd1: begin dr = 4'sd1; dc = 4'sd0;  end
            2'd2: begin dr = 4'sd1; dc = 4'sd1;  end
            default: begin dr = 4'sd1; dc = -4'sd1; end
        endcase
        nr = (state == CHK_NEG) ? probe_r - dr : probe_r + dr;
        nc = (state == CHK_NEG) ? probe_c - dc : probe_c + dc;
        // Coordinates only reach -1..8; both have bit 3 set, 0..7 do not.
        in_bounds  = ~nr[3] & ~nc[3];
        take_step  = in_bounds && (board[nr[2:0]][nc[2:0]] == current_player) && (run_cnt < WIN);
        stop_dir   = !take_step || (run_cnt + 4'd1 >= WIN);
        scan_empty = (board[scan_row][current_col] == 2'b00);
        win        = (run_cnt >= WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (ev_d) next_state = game_over ? CLEAR : SCAN;
            SCAN:     if (scan_empty) next_state = PLACE;
                      else if (scan_row == 3'd7) next_state = IDLE;
            PLACE:    next_state = CHK_POS;
            CHK_POS:  if (stop_dir) next_state = CHK_NEG;
            CHK_NEG:  if (stop_dir) next_state = NEXT_DIR;
            NEXT_DIR: if (!win && dir_idx != 2'd3) next_state = CHK_POS;
                      else next_state = RESOLVE;
            RESOLVE:  next_state = IDLE;
            CLEAR:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    board[i][j] <= 2'b00;
            current_col <= '0; current_player <= 2'b01;
            game_over <= 1'b0; winner <= 2'b00;
            scan_row <= '0; pl_row <= '0; pl_col <= '0;
            move_cnt <= '0; dir_idx <= '0; run_cnt <= '0;
            probe_r <= '0; probe_c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_d) scan_row <= '0;
                    else if (!game_over && ev_r && !ev_l && current_col != 3'd7)
                        current_col <= current_col + 3'd1;
                    else if (!game_over && ev_l && !ev_r && current_col != 3'd0)
                        current_col <= current_col - 3'd1;
                end
                SCAN: if (!scan_empty) scan_row <= scan_row + 3'd1;
                PLACE: begin
                    board[scan_row][current_col] <= current_player;
                    pl_row   <= scan_row;
                    pl_col   <= current_col;
                    move_cnt <= move_cnt + 7'd1;
                    dir_idx  <= '0;
                    run_cnt  <= 4'd1;
                    probe_r  <= {1'b0, scan_row};
                    probe_c  <= {1'b0, current_col};
                end
                CHK_POS, CHK_NEG: begin
                    if (take_step) begin
                        run_cnt <= run_cnt + 4'd1;
                        probe_r <= nr;
                        probe_c <= nc;
                    end
                    // each leg of a direction starts again from the placed cell
                    if (stop_dir) begin
                        probe_r <= {1'b0, pl_row};
                        probe_c <= {1'b0, pl_col};
                    end
                end
                NEXT_DIR: if (!win && dir_idx != 2'd3) begin
                    dir_idx <= dir_idx + 2'd1;
                    run_cnt <= 4'd1;
                end
                RESOLVE: begin
                    if (win) begin
                        game_over <= 1'b1;
                        winner    <= current_player;
                    end else if (move_cnt == 7'd64) begin
                        game_over <= 1'b1;
                        winner    <= 2'b00;
                    end else begin
                        current_player <= ~current_player;
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < 8; i++)
                        for (int j = 0; j < 8; j++)
                            board[i][j] <= 2'b00;
                    move_cnt <= '0; game_over <= 1'b0; winner <= 2'b00;
                    current_player <= 2'b01; current_col <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_connect_four_engine.sv
// tb/tb_connect_four_engine.sv - directed self-checking bench for connect_four_engine
module tb_connect_four_engine;
    logic       clk = 1'b0;
    logic       rst, move_right, move_left, drop_piece;
    logic [2:0] row_read, col_read;
    logic [1:0] data_out, current_player, winner;
    logic [2:0] current_col;
    logic       game_over, busy;

    int checks = 0;
    int errors = 0;
    int exp_col = 0;
    int bc;

    connect_four_engine #(.WIN_LEN(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .move_right(move_right), .move_left(move_left),
        .drop_piece(drop_piece), .row_read(row_read), .col_read(col_read),
        .data_out(data_out), .current_col(current_col), .current_player(current_player),
        .game_over(game_over), .winner(winner), .busy(busy)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cell(input string tag, input int r, input int c, input logic [1:0] exp);
        row_read = 3'(r);
        col_read = 3'(c);
        #1;
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    // which: 0 right, 1 left, 2 drop, 3 right+left together
    task automatic press(input int which, output int busy_cycles);
        busy_cycles = 0;
        case (which)
            0: move_right = 1'b1;
            1: move_left  = 1'b1;
            2: drop_piece = 1'b1;
            default: begin move_right = 1'b1; move_left = 1'b1; end
        endcase
        repeat (3) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        chk("settle", 32'(busy), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic goto_col(input int c);
        int b;
        while (exp_col < c) begin press(0, b); exp_col++; end
        while (exp_col > c) begin press(1, b); exp_col--; end
    endtask

    task automatic drop_at(input int c, output int busy_cycles);
        goto_col(c);
        press(2, busy_cycles);
    endtask

    task automatic do_reset();
        move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_col = 0;
    endtask

    initial begin
        int seq_h[7]  = '{0, 7, 1, 7, 2, 7, 3};
        int seq_v[7]  = '{0, 1, 0, 1, 0, 1, 0};
        int seq_dp[11] = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 6, 3};
        int seq_dn[11] = '{7, 6, 6, 5, 5, 4, 5, 4, 4, 1, 4};
        int seq_nw[5] = '{5, 4, 6, 0, 7};
        int ord_e[8]  = '{0, 2, 1, 3, 4, 6, 5, 7};
        int ord_o[8]  = '{2, 0, 3, 1, 6, 4, 7, 5};
        int nonzero;

        rst = 1'b1; move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
        row_read = '0; col_read = '0;
        do_reset();

        // reset state
        chk("rst_col", 32'(current_col), 0);
        chk("rst_player", 32'(current_player), 1);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_busy", 32'(busy), 0);
        chk_cell("rst_cell00", 0, 0, 2'b00);
        chk_cell("rst_cell77", 7, 7, 2'b00);

        // cursor movement and saturation
        repeat (3) press(0, bc);
        press(1, bc);
        chk("col_after_rrrl", 32'(current_col), 2);
        repeat (10) press(0, bc);
        chk("col_saturate_7", 32'(current_col), 7);
        exp_col = 7;

        // two drops into column 3
        drop_at(3, bc);
        chk_cell("drop1_cell", 0, 3, 2'b01);
        chk("drop1_player", 32'(current_player), 2);
        drop_at(3, bc);
        chk_cell("drop2_cell", 1, 3, 2'b10);
        chk("drop2_player", 32'(current_player), 1);

        // fill column 0, then drop into the full column
        for (int i = 0; i < 8; i++) drop_at(0, bc);
        chk("fill_player", 32'(current_player), 1);
        drop_at(0, bc);
        chk("full_latency_ok", 32'(bc <= 9), 1);
        for (int r = 0; r < 8; r++)
            chk_cell("full_col_cell", r, 0, (r % 2 == 0) ? 2'b01 : 2'b10);
        chk("full_player", 32'(current_player), 1);
        chk("full_game_over", 32'(game_over), 0);

        // horizontal win
        do_reset();
        foreach (seq_h[i]) drop_at(seq_h[i], bc);
        chk("h_game_over", 32'(game_over), 1);
        chk("h_winner", 32'(winner), 1);
        chk("h_player", 32'(current_player), 1);

        // vertical win
        do_reset();
        foreach (seq_v[i]) drop_at(seq_v[i], bc);
        chk("v_game_over", 32'(game_over), 1);
        chk("v_winner", 32'(winner), 1);

        // (+1,+1) diagonal win
        do_reset();
        for (int i = 0; i < 10; i++) drop_at(seq_dp[i], bc);
        chk("dp_not_yet", 32'(game_over), 0);
        drop_at(seq_dp[10], bc);
        chk("dp_game_over", 32'(game_over), 1);
        chk("dp_winner", 32'(winner), 1);

        // (+1,-1) diagonal win
        do_reset();
        foreach (seq_dn[i]) drop_at(seq_dn[i], bc);
        chk("dn_game_over", 32'(game_over), 1);
        chk("dn_winner", 32'(winner), 1);

        // three in a row blocked by the opponent at col 4
        do_reset();
        foreach (seq_nw[i]) drop_at(seq_nw[i], bc);
        chk("nw_game_over", 32'(game_over), 0);
        chk("nw_winner", 32'(winner), 0);
        chk("nw_player", 32'(current_player), 2);

        // full board with no four-in-a-row -> draw
        do_reset();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) begin
                if (r == 7 && i == 7) chk("draw_not_yet", 32'(game_over), 0);
                drop_at((r % 2 == 0) ? ord_e[i] : ord_o[i], bc);
            end
        chk("draw_game_over", 32'(game_over), 1);
        chk("draw_winner", 32'(winner), 0);
        chk("draw_player", 32'(current_player), 2);
        chk_cell("draw_cell00", 0, 0, 2'b01);
        chk_cell("draw_cell02", 0, 2, 2'b10);
        chk_cell("draw_cell10", 1, 0, 2'b10);
        chk_cell("draw_cell77", 7, 7, 2'b01);
        chk_cell("draw_cell75", 7, 5, 2'b10);

        // drop while game over restarts the game
        press(2, bc);
        exp_col = 0;
        nonzero = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                row_read = 3'(r);
                col_read = 3'(c);
                #1;
                if (data_out != 2'b00) nonzero++;
            end
        chk("clear_nonzero_cells", 32'(nonzero), 0);
        chk("clear_player", 32'(current_player), 1);
        chk("clear_game_over", 32'(game_over), 0);
        chk("clear_winner", 32'(winner), 0);
        chk("clear_col", 32'(current_col), 0);

        // button held across reset gives no event
        move_right = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_first_event", 32'(current_col), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("in_rst_col", 32'(current_col), 0);
        chk("in_rst_player", 32'(current_player), 1);
        chk("in_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_through_rst", 32'(current_col), 0);
        move_right = 1'b0;
        repeat (5) @(negedge clk);
        press(0, bc);
        chk("repress_after_rst", 32'(current_col), 1);
        exp_col = 1;

        // reset during SCAN aborts the drop
        drop_piece = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("scan_started", 32'(busy), 1);
        rst = 1'b1;
        drop_piece = 1'b0;
        chk_cell("abort_cell01", 0, 1, 2'b00);
        chk("abort_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_col = 0;
        chk("abort_col", 32'(current_col), 0);
        chk("abort_player", 32'(current_player), 1);

        // simultaneous left and right are ignored
        goto_col(2);
        press(3, bc);
        chk("both_ignored", 32'(current_col), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
